core_fifo_mc: RTL
=================

// Module: core_fifo_mc
// PURPOSE
//  Multi-channel, memory-mapped FIFO on the core load/store interface; NUM_CHANNELS independent FIFOs.
//  Word address selects the channel; one extra address bit selects a per-channel status/flush register.
//  Core stores push data, loads pop it; registered read response with valid flag, write-accept backpressure.
// PARAMETERS
//  INTERFACE_WIDTH       32  data width, bytes = INTERFACE_WIDTH/8; must be >= 16
//  INTERFACE_ADDR_WIDTH  32  address width
//  NUM_CHANNELS          4   FIFO count, power of 2, >= 1
//  DEPTH                 16  entries per channel, power of 2, >= 2
//  ADDR_LSB              2   byte-offset bits ignored in address decode
// PORTS
//  iClk            in   1                      clock, all logic on rising edge
//  iReset          in   1                      synchronous, active-high reset
//  iWriteAddress   in   INTERFACE_ADDR_WIDTH   push/flush target address
//  iReadAddress    in   INTERFACE_ADDR_WIDTH   pop/status target address
//  iWriteEnable    in   INTERFACE_WIDTH/8      byte enables for push data
//  iWriteData      in   INTERFACE_WIDTH        push data
//  iReadRequest    in   1                      read (pop or status) request
//  iWriteRequest   in   1                      write (push or flush) request
//  oReadData       out  INTERFACE_WIDTH        registered read data
//  oReadDataValid  out  1                      registered, high one cycle after a serviced read
//  oWriteAccept    out  1                      combinational, write accepted this cycle
// BEHAVIOUR
//  Decode: CH = addr[ADDR_LSB +: CH_BITS] (CH_BITS=clog2(NUM_CHANNELS), 0 if 1 ch); STS = addr[ADDR_LSB+CH_BITS]; upper bits ignored.
//  Reset: all rd/wr pointers and counts 0, oReadData=0, oReadDataValid=0; storage contents not cleared.
//  Push (iWriteRequest, STS=0): oWriteAccept = !full[CH] | pop_same_ch; accepted -> store word with
//   disabled bytes forced to 0, wr_ptr+1 (wraps mod DEPTH), count+1. Not accepted -> no state change.
//  Flush (iWriteRequest, STS=1): always accepted regardless of iWriteEnable; channel ptrs and count -> 0.
//  Pop (iReadRequest, STS=0): non-empty -> next cycle oReadData=head word, valid=1; rd_ptr+1, count-1.
//   Empty -> next cycle valid=0, oReadData holds, no state change (core retries).
//  Status read (iReadRequest, STS=1): non-destructive; next cycle valid=1, oReadData =
//   {full @ bit W-1, empty @ bit W-2, zeros, count[clog2(DEPTH):0] @ LSBs}; value sampled pre-update.
//  No iReadRequest: next cycle valid=0, oReadData holds.
//  Latency: read 1 cycle; push visible to a pop issued the following cycle (no same-cycle bypass).
//  Simultaneous push+pop same channel: both act, count unchanged; allowed when full (pop frees slot)
//   and when empty (pop sees empty, returns valid=0; push still lands).
//  Flush + pop same channel same cycle: flush wins, pop response valid=0.
//  Flush + status read same channel: status returns pre-flush value.
//  Push+pop different channels: fully independent. Count range 0..DEPTH (width clog2(DEPTH)+1).
//  Reset during traffic: reset wins over every request in that cycle; outputs 0 next cycle.
// STRUCTURE
//  core_fifo_pkg: clog2 function, CH_BITS, PTR_W, CNT_W, status bit positions (STS_FULL_BIT, STS_EMPTY_BIT).
//  Sub-module core_fifo_channel: single DEPTH x INTERFACE_WIDTH FIFO with push/pop/flush, full/empty/count,
//   async-read head; instantiated NUM_CHANNELS times via generate.
//  Top: address decode, byte masking, read-mux, registered response stage, accept logic.
// TESTING
//  Reset then status read ch0 (addr 0x10) -> next cycle valid=1, data=0x4000_0000 (empty=1, count=0).
//  Push 0xDEADBEEF,0x12345678 to ch1 (addr 0x04, we=4'hF), pop ch1 twice -> same order, valid=1 each; 3rd pop -> valid=0.
//  Push 16 words to ch2, 17th push -> oWriteAccept=0; 17th push with concurrent ch2 pop -> accepted, count stays 16.
//  Push 0xAABBCCDD with we=4'b0101 to ch3 -> pop returns 0x00BB00DD.
//  Fill ch0 with 5 words, write status addr 0x10 (flush) + same-cycle pop ch0 -> pop valid=0, status count=0.
//  Interleaved random push/pop on all 4 channels vs reference queue model, iReset pulsed mid-run -> all empty, valid=0.

Source files
------------

// File: rtl/core_fifo_pkg.sv
// Shared constants and helpers for the multi-channel memory-mapped FIFO.
package core_fifo_pkg;

  // Ceiling log2; returns 0 for n <= 1 so a single channel needs no select bits.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = (n > 0) ? n - 1 : 0; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  localparam int unsigned DEFAULT_CHANNELS = 4;
  localparam int unsigned DEFAULT_DEPTH    = 16;
  localparam int unsigned CH_BITS          = clog2(DEFAULT_CHANNELS);
  localparam int unsigned PTR_W            = clog2(DEFAULT_DEPTH);
  localparam int unsigned CNT_W            = PTR_W + 1;

  // Status flag positions, counted down from the MSB of the data word.
  localparam int unsigned STS_FULL_FROM_MSB  = 0;
  localparam int unsigned STS_EMPTY_FROM_MSB = 1;

  function automatic int unsigned stsFullBit(input int unsigned w);
    return w - 1 - STS_FULL_FROM_MSB;
  endfunction

  function automatic int unsigned stsEmptyBit(input int unsigned w);
    return w - 1 - STS_EMPTY_FROM_MSB;
  endfunction

endpackage

// File: rtl/core_fifo_channel.sv
// Single-channel FIFO: push/pop/flush, occupancy count and an async-read head word.
module core_fifo_channel
  import core_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                    iClk,
  input  logic                    iReset,
  input  logic                    iPush,
  input  logic                    iPop,
  input  logic                    iFlush,
  input  logic [WIDTH-1:0]        iPushData,
  output logic [WIDTH-1:0]        oHead,
  output logic                    oFull,
  output logic                    oEmpty,
  output logic [clog2(DEPTH):0]   oCount
);

  localparam int unsigned PW = clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic             doPush;
  logic             doPop;

  assign oFull  = (count == CW'(DEPTH));
  assign oEmpty = (count == '0);
  assign oCount = count;
  assign oHead  = mem[rdPtr];

  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign doPop  = iPop & ~oEmpty & ~iFlush;
  assign doPush = iPush & (~oFull | doPop);

  always_ff @(posedge iClk) begin
    if (iReset || iFlush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtr + PW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (doPush && !iReset) mem[wrPtr] <= iPushData;
  end

endmodule

// File: rtl/core_fifo_mc.sv
// Memory-mapped multi-channel FIFO: address decode, byte masking, read mux and registered response.
module core_fifo_mc
  import core_fifo_pkg::*;
#(
  parameter int unsigned INTERFACE_WIDTH      = 32,
  parameter int unsigned INTERFACE_ADDR_WIDTH = 32,
  parameter int unsigned NUM_CHANNELS         = 4,
  parameter int unsigned DEPTH                = 16,
  parameter int unsigned ADDR_LSB             = 2
) (
  input  logic                              iClk,
  input  logic                              iReset,
  input  logic [INTERFACE_ADDR_WIDTH-1:0]   iWriteAddress,
  input  logic [INTERFACE_ADDR_WIDTH-1:0]   iReadAddress,
  input  logic [INTERFACE_WIDTH/8-1:0]      iWriteEnable,
  input  logic [INTERFACE_WIDTH-1:0]        iWriteData,
  input  logic                              iReadRequest,
  input  logic                              iWriteRequest,
  output logic [INTERFACE_WIDTH-1:0]        oReadData,
  output logic                              oReadDataValid,
  output logic                              oWriteAccept
);

  localparam int unsigned BYTES     = INTERFACE_WIDTH / 8;
  localparam int unsigned CHB       = clog2(NUM_CHANNELS);
  localparam int unsigned CH_IDX_W  = (CHB == 0) ? 1 : CHB;
  localparam int unsigned CW        = clog2(DEPTH) + 1;
  localparam int unsigned STS_BIT   = ADDR_LSB + CHB;
  localparam int unsigned FULL_BIT  = stsFullBit(INTERFACE_WIDTH);
  localparam int unsigned EMPTY_BIT = stsEmptyBit(INTERFACE_WIDTH);

  logic [CH_IDX_W-1:0]        wrCh;
  logic [CH_IDX_W-1:0]        rdCh;
  logic                       pushReq;
  logic                       flushReq;
  logic                       popReq;
  logic                       statusReq;
  logic                       popSameCh;
  logic                       popOk;
  logic [INTERFACE_WIDTH-1:0] maskedData;
  logic [INTERFACE_WIDTH-1:0] statusWord;
  logic [INTERFACE_WIDTH-1:0] chHead  [NUM_CHANNELS];
  logic                       chFull  [NUM_CHANNELS];
  logic                       chEmpty [NUM_CHANNELS];
  logic [CW-1:0]              chCount [NUM_CHANNELS];
  logic                       unusedAddr;

  assign unusedAddr = ^{iWriteAddress, iReadAddress};

  generate
    if (CHB == 0) begin : gSingleCh
      assign wrCh = '0;
      assign rdCh = '0;
    end else begin : gMultiCh
      assign wrCh = iWriteAddress[ADDR_LSB +: CHB];
      assign rdCh = iReadAddress[ADDR_LSB +: CHB];
    end
  endgenerate

  assign pushReq   = iWriteRequest & ~iWriteAddress[STS_BIT] & ~iReset;
  assign flushReq  = iWriteRequest &  iWriteAddress[STS_BIT] & ~iReset;
  assign popReq    = iReadRequest  & ~iReadAddress[STS_BIT]  & ~iReset;
  assign statusReq = iReadRequest  &  iReadAddress[STS_BIT];
  assign popSameCh = popReq & (rdCh == wrCh);

  // A flush on the popped channel wins; the pop then reports no data.
  assign popOk = popReq & ~chEmpty[rdCh] & ~(flushReq & (rdCh == wrCh));

  assign oWriteAccept = flushReq | (pushReq & (~chFull[wrCh] | popSameCh));

  always_comb begin
    maskedData = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (iWriteEnable[b]) maskedData[b*8 +: 8] = iWriteData[b*8 +: 8];
    end
  end

  always_comb begin
    statusWord            = '0;
    statusWord[CW-1:0]    = chCount[rdCh];
    statusWord[FULL_BIT]  = chFull[rdCh];
    statusWord[EMPTY_BIT] = chEmpty[rdCh];
  end

  generate
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : gCh
      core_fifo_channel #(
        .WIDTH (INTERFACE_WIDTH),
        .DEPTH (DEPTH)
      ) uChannel (
        .iClk      (iClk),
        .iReset    (iReset),
        .iPush     (pushReq  & (wrCh == CH_IDX_W'(c))),
        .iPop      (popReq   & (rdCh == CH_IDX_W'(c))),
        .iFlush    (flushReq & (wrCh == CH_IDX_W'(c))),
        .iPushData (maskedData),
        .oHead     (chHead[c]),
        .oFull     (chFull[c]),
        .oEmpty    (chEmpty[c]),
        .oCount    (chCount[c])
      );
    end
  endgenerate

  // Response stage; data holds whenever nothing was serviced.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      oReadData      <= '0;
      oReadDataValid <= 1'b0;
    end else begin
      oReadDataValid <= 1'b0;
      if (statusReq) begin
        oReadData      <= statusWord;
        oReadDataValid <= 1'b1;
      end else if (popOk) begin
        oReadData      <= chHead[rdCh];
        oReadDataValid <= 1'b1;
      end
    end
  end

endmodule
